// File: rtl/ring_output_arbiter.sv
// Output-port scheduler for the ring router. A round-robin arbiter grants one
// requesting input controller per cycle into the VC buffer of the current
// polarity. The buffer of the opposite polarity is offered on the outbound link.
module ring_output_arbiter #(
  parameter int NUM_REQ           = 3,
  parameter int BUFFER_DATA_WIDTH = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     sig_req_channel,
  input  logic [NUM_REQ*BUFFER_DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                     sig_channel_clean,
  output logic                                   polarity,
  output logic                                   sendO,
  output logic [BUFFER_DATA_WIDTH-1:0]           dataO,
  input  logic                                   receiveO
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]             rr_ptr_reg;
  logic [PTR_W-1:0]             rr_ptr_next;
  logic [PTR_W-1:0]             grant_idx;
  logic [PTR_W:0]               scan_sum;
  logic                         grant_valid;
  logic [BUFFER_DATA_WIDTH-1:0] grant_data;
  logic                         drain;
  logic                         polarity_reg;
  logic [1:0]                   vc_valid;
  logic [BUFFER_DATA_WIDTH-1:0] vc_data [2];

  assign polarity = polarity_reg;

  // Round-robin scan starting at the pointer; blocked while the writable VC is
  // still occupied or while reset is held.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    if (rst && !vc_valid[polarity_reg]) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_sum = {1'b0, rr_ptr_reg} + (PTR_W+1)'(k);
        if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
          scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
        end
        if (!grant_valid && sig_req_channel[scan_sum[PTR_W-1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = scan_sum[PTR_W-1:0];
        end
      end
    end
  end

  // One-hot grant, next pointer and the granted requester's flit.
  always_comb begin
    sig_channel_clean = '0;
    rr_ptr_next       = rr_ptr_reg;
    grant_data        = req_data[int'(grant_idx)*BUFFER_DATA_WIDTH +: BUFFER_DATA_WIDTH];
    if (grant_valid) begin
      sig_channel_clean = NUM_REQ'(1) << grant_idx;
      rr_ptr_next = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // Link side: offer the VC that arbitration is not allowed to touch this cycle.
  assign sendO = vc_valid[~polarity_reg];
  assign dataO = sendO ? vc_data[~polarity_reg] : '0;
  assign drain = sendO & receiveO;

  // Polarity flips every cycle; the pointer advances past each granted requester.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      polarity_reg <= 1'b0;
      rr_ptr_reg   <= '0;
    end else begin
      polarity_reg <= ~polarity_reg;
      rr_ptr_reg   <= rr_ptr_next;
    end
  end

  // Even (gi=0) and odd (gi=1) one-entry VC buffers.
  for (genvar gi = 0; gi < 2; gi++) begin : g_vc
    logic                         valid_reg;
    logic [BUFFER_DATA_WIDTH-1:0] data_reg;

    // Written only in its own phase, drained only in the opposite phase.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
      end else if (polarity_reg == 1'(gi)) begin
        if (grant_valid) begin
          valid_reg <= 1'b1;
          data_reg  <= grant_data;
        end
      end else if (drain) begin
        valid_reg <= 1'b0;
      end
    end

    assign vc_valid[gi] = valid_reg;
    assign vc_data[gi]  = data_reg;
  end

endmodule

// File: tb/tb_ring_output_arbiter.sv
// Bench for ring_output_arbiter: directed vector table, an asynchronous reset
// sequence, then randomized traffic checked against a behavioural model.
module tb_ring_output_arbiter;

  localparam int N = 3;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0]   clean;
  logic           pol;
  logic           send_o;
  logic [W-1:0]   data_o;
  logic           recv = 1'b1;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // model state: two VC slots, phase bit, round-robin pointer
  logic         m_pol;
  logic [1:0]   m_full;
  logic [W-1:0] m_buf [2];
  int           m_ptr;

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic           recv;
    logic [N-1:0]   g;
    logic           s;
    logic [W-1:0]   d;
    logic           p;
  } vec_t;

  vec_t vecs[$];

  ring_output_arbiter #(.NUM_REQ(N), .BUFFER_DATA_WIDTH(W)) dut (
    .clk               (clk),
    .rst               (rst),
    .sig_req_channel   (req),
    .req_data          (data),
    .sig_channel_clean (clean),
    .polarity          (pol),
    .sendO             (send_o),
    .dataO             (data_o),
    .receiveO          (recv)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [N-1:0] r, input logic [W-1:0] d0,
                              input logic [W-1:0] d1, input logic [W-1:0] d2,
                              input logic rv, input logic [N-1:0] g,
                              input logic s, input logic [W-1:0] d, input logic p);
    vec_t v;
    v.req = r; v.data = {d2, d1, d0}; v.recv = rv;
    v.g = g; v.s = s; v.d = d; v.p = p;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_pol = 1'b0; m_full = 2'b00; m_buf[0] = '0; m_buf[1] = '0; m_ptr = 0;
  endtask

  // winner = first requester at or after the pointer, going round the ring
  function automatic int model_winner(input logic [N-1:0] r);
    if (m_full[m_pol]) return -1;
    for (int k = 0; k < N; k++) begin
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Apply inputs, compare at the falling edge, advance model on the rising edge.
  task automatic do_cycle(input logic [N-1:0] r, input logic [N*W-1:0] dv,
                          input logic rv, input bit use_tab, input vec_t v,
                          input string tag);
    int           win;
    logic [N-1:0] eg;
    logic         es;
    logic [W-1:0] ed;
    logic         ep;
    req = r; data = dv; recv = rv;
    @(negedge clk);
    win = model_winner(r);
    if (use_tab) begin
      eg = v.g; es = v.s; ed = v.d; ep = v.p;
    end else begin
      eg = (win >= 0) ? N'(1) << win : '0;
      es = m_full[~m_pol];
      ed = es ? m_buf[~m_pol] : '0;
      ep = m_pol;
    end
    chk({"grant@", tag}, W'(clean), W'(eg));
    chk({"sendO@", tag}, W'(send_o), W'(es));
    chk({"dataO@", tag}, data_o, ed);
    chk({"polarity@", tag}, W'(pol), W'(ep));
    $display("cycle %s req=%b recv=%b grant=%b sendO=%b dataO=%h pol=%b",
             tag, r, rv, clean, send_o, data_o, pol);
    @(posedge clk);
    if (rv && m_full[~m_pol]) m_full[~m_pol] = 1'b0;
    if (win >= 0) begin
      m_buf[m_pol]  = dv[win*W +: W];
      m_full[m_pol] = 1'b1;
      m_ptr         = (win + 1) % N;
    end
    m_pol = ~m_pol;
    #1;
  endtask

  initial begin
    vec_t dummy;
    dummy = mk('0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);

    // polarity after release
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 1));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 1));
    // round robin, all requesting
    vecs.push_back(mk(3'b111, 1, 2, 3, 1, 3'b001, 0, 0, 0));
    vecs.push_back(mk(3'b111, 1, 2, 3, 1, 3'b010, 1, 1, 1));
    vecs.push_back(mk(3'b111, 1, 2, 3, 1, 3'b100, 1, 2, 0));
    vecs.push_back(mk(3'b111, 1, 2, 3, 1, 3'b001, 1, 3, 1));
    vecs.push_back(mk(3'b111, 1, 2, 3, 1, 3'b010, 1, 1, 0));
    vecs.push_back(mk(3'b111, 1, 2, 3, 1, 3'b100, 1, 2, 1));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 3'b000, 1, 3, 0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 1));
    // single flit
    vecs.push_back(mk(3'b001, 64'hA5A5A5A5A5A5A5A5, 0, 0, 1, 3'b001, 0, 0, 0));
    vecs.push_back(mk(3'b000, 64'hA5A5A5A5A5A5A5A5, 0, 0, 1, 3'b000, 1, 64'hA5A5A5A5A5A5A5A5, 1));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0));
    // backpressure
    vecs.push_back(mk(3'b001, 64'h11, 0, 0, 0, 3'b001, 0, 0, 1));
    vecs.push_back(mk(3'b001, 64'h22, 0, 0, 0, 3'b001, 1, 64'h11, 0));
    vecs.push_back(mk(3'b001, 64'h33, 0, 0, 0, 3'b000, 1, 64'h22, 1));
    vecs.push_back(mk(3'b001, 64'h33, 0, 0, 1, 3'b000, 1, 64'h11, 0));
    vecs.push_back(mk(3'b001, 64'h33, 0, 0, 1, 3'b001, 1, 64'h22, 1));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 3'b000, 1, 64'h33, 0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 1));
    // pointer wrap with sparse requests
    vecs.push_back(mk(3'b100, 0, 0, 64'h44, 1, 3'b100, 0, 0, 0));
    vecs.push_back(mk(3'b101, 64'h55, 0, 64'h66, 1, 3'b001, 1, 64'h44, 1));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 3'b000, 1, 64'h55, 0));

    // held in reset with all requesters active
    rst = 1'b0; req = 3'b111; data = {64'h3, 64'h2, 64'h1}; recv = 1'b1;
    model_reset();
    @(negedge clk);
    chk("reset_grant", W'(clean), '0);
    chk("reset_sendO", W'(send_o), '0);
    chk("reset_dataO", data_o, '0);
    chk("reset_polarity", W'(pol), '0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      do_cycle(vecs[i].req, vecs[i].data, vecs[i].recv, 1'b1, vecs[i], $sformatf("row%0d", i));
    end

    // fill both VCs under backpressure, then reset between edges
    do_cycle(3'b001, {64'h0, 64'h0, 64'h77}, 1'b0, 1'b0, dummy, "fill0");
    do_cycle(3'b001, {64'h0, 64'h0, 64'h88}, 1'b0, 1'b0, dummy, "fill1");
    #2 rst = 1'b0;
    #1;
    chk("async_sendO", W'(send_o), '0);
    chk("async_dataO", data_o, '0);
    chk("async_grant", W'(clean), '0);
    chk("async_polarity", W'(pol), '0);
    model_reset();
    @(posedge clk); #1;
    chk("async_hold_sendO", W'(send_o), '0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_cycle(3'b000, '0, 1'b1, 1'b0, dummy, $sformatf("post%0d", i));
    end
    do_cycle(3'b111, {64'h3, 64'h2, 64'h1}, 1'b1, 1'b0, dummy, "post_rr");

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [N*W-1:0] dv;
      for (int j = 0; j < N; j++) dv[j*W +: W] = {$urandom, $urandom};
      do_cycle(N'($urandom_range(0, 7)), dv, ($urandom_range(0, 3) != 0),
               1'b0, dummy, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
